ripple_counter_ctrl: RTL and testbench

Run controller and two-requester arbiter for the 4-bit up/down ripple counter. Two clients each request a counting run (direction plus step count); the block arbitrates round-robin, then drives the counter's enable/direction/clear controls for exactly the requested number of steps and reports completion. It sits between the client logic and the counter datapath, which it controls but does not observe.

---
 rtl/ripple_counter_ctrl.sv | 114 +++++++++++
 tb/tb_ripple_counter_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ripple_counter_ctrl.sv
// Run controller and round-robin arbiter for a 4-bit up/down ripple counter.
// Define CNT_CLEAR_EN to clear the counter before each non-zero run.
module ripple_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       req_dir,
  input  logic [WIDTH-1:0] req_len0,
  input  logic [WIDTH-1:0] req_len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             cnt_en,
  output logic             cnt_dir,
  output logic             cnt_clr
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             prio, prio_nxt;
  logic             owner, owner_nxt;
  logic             dir, dir_nxt;
  logic [WIDTH-1:0] remaining, rem_nxt;
  logic [1:0]       gnt_nxt;
  logic             win;
  logic [WIDTH-1:0] len_win;

  always_comb begin
    if (req == 2'b11) win = prio;
    else              win = req[1];
    len_win = win ? req_len1 : req_len0;
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    owner_nxt = owner;
    dir_nxt   = dir;
    rem_nxt   = remaining;
    gnt_nxt   = 2'b00;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt = win;
          dir_nxt   = req_dir[win];
          rem_nxt   = len_win;
          gnt_nxt   = win ? 2'b10 : 2'b01;
          // A zero-length run still spends its grant cycle in RUN, with no steps.
`ifdef CNT_CLEAR_EN
          state_nxt = (len_win != '0) ? CLEAR : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      CLEAR: state_nxt = RUN;
      RUN: begin
        if (remaining <= WIDTH'(1)) begin
          state_nxt = DONE;
          rem_nxt   = '0;
        end else begin
          rem_nxt = remaining - WIDTH'(1);
        end
      end
      DONE: begin
        prio_nxt  = ~owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      dir       <= 1'b0;
      remaining <= '0;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      cnt_en    <= 1'b0;
      cnt_dir   <= 1'b0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      owner     <= owner_nxt;
      dir       <= dir_nxt;
      remaining <= rem_nxt;
      gnt       <= gnt_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      done_id   <= (state_nxt == DONE) ? owner_nxt : 1'b0;
      cnt_en    <= (state_nxt == RUN) && (rem_nxt != '0);
      cnt_dir   <= ((state_nxt == RUN) && (rem_nxt != '0)) ? dir_nxt : 1'b0;
    end
  end

`ifdef CNT_CLEAR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_clr <= 1'b0;
    else      cnt_clr <= (state_nxt == CLEAR);
  end
`else
  assign cnt_clr = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_counter_ctrl.sv
// Directed bench for ripple_counter_ctrl with a behavioural 4-bit counter attached.
// Expected values are hand-derived; CNT_CLEAR_EN selects the matching expectations.
module tb_ripple_counter_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, req_dir;
  logic [3:0] req_len0, req_len1;
  logic [1:0] gnt;
  logic       busy, done, done_id, cnt_en, cnt_dir, cnt_clr;

  logic       ld;
  logic [3:0] ld_val;
  logic [3:0] ctr;

  int checks   = 0;
  int failures = 0;

  ripple_counter_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir),
    .req_len0(req_len0), .req_len1(req_len1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld)           ctr <= ld_val;
    else if (cnt_clr) ctr <= 4'd0;
    else if (cnt_en)  ctr <= cnt_dir ? ctr + 4'd1 : ctr - 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic load_ctr(input logic [3:0] v);
    ld = 1'b1; ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Called at the negedge before the sampling edge; returns at the DONE cycle's negedge.
  task automatic expect_run(input logic id, input logic d, input int len);
    @(negedge clk);
    check("gnt", {30'd0, gnt}, id ? 32'd2 : 32'd1);
    check("busy_gnt", busy, 1);
`ifdef CNT_CLEAR_EN
    if (len != 0) begin
      check("clr_gnt", cnt_clr, 1);
      check("en_in_clr", cnt_en, 0);
      @(negedge clk);
      check("gnt_after_clr", {30'd0, gnt}, 0);
    end
`else
    check("clr_off", cnt_clr, 0);
`endif
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      check("cnt_en", cnt_en, 1);
      check("cnt_dir", cnt_dir, d);
      check("no_done_run", done, 0);
    end
    if (len == 0) check("en_len0", cnt_en, 0);
    @(negedge clk);
    check("done", done, 1);
    check("done_id", done_id, id);
    check("en_in_done", cnt_en, 0);
    check("busy_done", busy, 1);
  endtask

  initial begin
    int n;
    rst = 1'b0; req = 2'b00; req_dir = 2'b00; req_len0 = 4'd0; req_len1 = 4'd0;
    ld = 1'b0; ld_val = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_outs", {gnt, busy, done, done_id, cnt_en, cnt_dir, cnt_clr}, 0);
    rst = 1'b1;
    load_ctr(4'd0);
    check("idle_busy", busy, 0);

    // single up run of 5
    req = 2'b01; req_dir = 2'b01; req_len0 = 4'd5;
    expect_run(1'b0, 1'b1, 5);
    req = 2'b00;
    check("t1_ctr", ctr, 5);
    @(negedge clk);
    check("t1_idle", busy, 0);

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // both requesting: grants alternate 0,1,0,1
    req = 2'b11; req_dir = 2'b01; req_len0 = 4'd3; req_len1 = 4'd2;
    expect_run(1'b0, 1'b1, 3);
    @(negedge clk); check("t2_idle0", busy, 0);
    expect_run(1'b1, 1'b0, 2);
    @(negedge clk); check("t2_idle1", busy, 0);
    expect_run(1'b0, 1'b1, 3);
    @(negedge clk); check("t2_idle2", busy, 0);
    expect_run(1'b1, 1'b0, 2);
    req = 2'b00;
    @(negedge clk); check("t2_idle3", busy, 0);

    // zero-length run from requester 1
    req = 2'b10; req_dir = 2'b10; req_len1 = 4'd0;
    expect_run(1'b1, 1'b1, 0);
    req = 2'b00;
    @(negedge clk);
    check("t3_idle", busy, 0);
    check("t3_done_off", done, 0);

    // reset in the middle of a run of 8
    req = 2'b01; req_dir = 2'b01; req_len0 = 4'd8;
    n = 0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      @(negedge clk);
      if (cnt_en) n++;
    end
    check("t4_steps", n, 2);
    #2 rst = 1'b0;
    #1 check("t4_async_rst", {gnt, busy, done, done_id, cnt_en, cnt_dir, cnt_clr}, 0);
    @(negedge clk);
    check("t4_no_done", done, 0);
    check("t4_busy", busy, 0);
    req = 2'b11; req_len0 = 4'd2; req_len1 = 4'd2;
    rst = 1'b1;
    expect_run(1'b0, 1'b1, 2);
    req = 2'b00;
    @(negedge clk);

    // down run of 15 from 0 wraps to 1
    load_ctr(4'd0);
    req = 2'b01; req_dir = 2'b00; req_len0 = 4'd15;
    expect_run(1'b0, 1'b0, 15);
    req = 2'b00;
    check("t5_ctr", ctr, 1);
    @(negedge clk);

    // up run of 4 from 9
    load_ctr(4'd9);
    req = 2'b01; req_dir = 2'b01; req_len0 = 4'd4;
    expect_run(1'b0, 1'b1, 4);
    req = 2'b00;
`ifdef CNT_CLEAR_EN
    check("t6_ctr", ctr, 4);
`else
    check("t6_ctr", ctr, 13);
`endif
    @(negedge clk);
    check("t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
